// File: rtl/register_pkg.sv
// Shared types and default sizing for the register bank and its consumers.
package register_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DONE
    } scan_state_t;

    localparam int unsigned REG_NUM_DEFAULT   = 16;
    localparam int unsigned REG_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/register_scan_streamer.sv
// Snapshots the register bank on a start request and streams an index range
// (wrapping past the top index) one word per valid/ready beat.
module register_scan_streamer
    import register_pkg::*;
#(
    parameter int unsigned NUM_REGS = REG_NUM_DEFAULT,
    parameter int unsigned WIDTH    = REG_WIDTH_DEFAULT,
    localparam int unsigned IW      = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] reg_q [NUM_REGS],
    input  logic             start,
    input  logic [IW-1:0]    first_idx,
    input  logic [IW-1:0]    last_idx,
    output logic             busy,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [IW-1:0]    m_idx,
    output logic             m_last,
    output logic             done,
    output logic             err
);

    scan_state_t      state_q, state_d;
    logic [WIDTH-1:0] shadow_q [NUM_REGS];
    logic [WIDTH-1:0] shadow_d [NUM_REGS];
    logic [IW-1:0]    last_q, last_d;
    logic [IW-1:0]    m_idx_q, m_idx_d;
    logic [WIDTH-1:0] m_data_q, m_data_d;
    logic             m_valid_q, m_valid_d;
    logic             m_last_q, m_last_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             idx_ok;
    logic             handshake;
    logic [IW-1:0]    next_idx;

    assign idx_ok    = (int'(first_idx) < int'(NUM_REGS)) && (int'(last_idx) < int'(NUM_REGS));
    assign handshake = m_valid_q && m_ready;
    assign next_idx  = (int'(m_idx_q) == int'(NUM_REGS - 1)) ? '0 : m_idx_q + IW'(1);

    // Next-state and output-register computation; m_idx_q doubles as the scan cursor.
    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        last_d    = last_q;
        m_idx_d   = m_idx_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (idx_ok) begin
                        shadow_d  = reg_q;
                        last_d    = last_idx;
                        m_idx_d   = first_idx;
                        m_data_d  = reg_q[first_idx];
                        m_last_d  = (first_idx == last_idx);
                        m_valid_d = 1'b1;
                        busy_d    = 1'b1;
                        state_d   = S_STREAM;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_STREAM: begin
                if (handshake) begin
                    if (m_last_q) begin
                        m_valid_d = 1'b0;
                        m_last_d  = 1'b0;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        m_idx_d  = next_idx;
                        m_data_d = shadow_q[next_idx];
                        m_last_d = (next_idx == last_q);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; the shadow array is intentionally not reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            last_q    <= '0;
            m_idx_q   <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            m_idx_q   <= m_idx_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
        shadow_q <= shadow_d;
    end

    assign busy    = busy_q;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_idx   = m_idx_q;
    assign m_last  = m_last_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule
